lsu_dmem_if: RTL and testbench
==============================

Name: lsu_dmem_if

Overview:
Load/store unit between the execute stage and the data-memory port. It accepts one memory operation at a time, encoded with the shared MEM_* 3-bit opcodes. Operations are handled as follows:
- Check alignment.
- Generate a word-aligned request with byte enables.
- Wait for the memory handshake.
- Return sign- or zero-extended load data to writeback.
- Stall execute (via ex_ready) while busy.

Parameters:
DATA_WIDTH, 32, data bus width (from shared package; only 32 supported)
ADDR_WIDTH, 32, address width (from shared package)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
ex_valid  in  1  execute stage presents a memory op
ex_ready  out  1  LSU can accept (high only in IDLE)
ex_mem_op  in  3  MEM_LB..MEM_SW opcode
ex_addr  in  ADDR_WIDTH  effective byte address
ex_wdata  in  DATA_WIDTH  store data (low bits significant for SB/SH)
ex_rd  in  5  load destination register
dmem_req  out  1  memory request, held until granted
dmem_we  out  1  1 = store
dmem_addr  out  ADDR_WIDTH  word-aligned address {addr[31:2],2'b00}
dmem_be  out  4  byte enables
dmem_wdata  out  DATA_WIDTH  lane-replicated store data
dmem_gnt  in  1  request accepted this cycle
dmem_rvalid  in  1  read data valid
dmem_rdata  in  DATA_WIDTH  read word
wb_valid  out  1  one-cycle pulse: load result or store completion
wb_we  out  1  1 when wb_valid is for a load (register write)
wb_rd  out  5  destination register
wb_data  out  DATA_WIDTH  extended load data (0 for stores)
lsu_misalign  out  1  one-cycle pulse: misaligned access dropped
lsu_bad_addr  out  ADDR_WIDTH  faulting address (valid with lsu_misalign)

Behaviour:
- Reset (async, rst_n=0): state IDLE. All of the following are 0: dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata, wb_valid, wb_we, wb_rd, wb_data, lsu_misalign, lsu_bad_addr. ex_ready=1 once rst_n=1.
- Accept: ex_valid && ex_ready on a rising edge. The LSU latches op, addr, wdata and rd.
- Misalignment is checked in the accept cycle:
  - LH/LHU/SH with addr[0]=1
  - LW/SW with addr[1:0]!=0
  - On a misaligned op: no memory request; next cycle lsu_misalign=1 and lsu_bad_addr=addr; state stays IDLE; wb_valid=0.
- States: IDLE, REQ, WAIT.
  - IDLE -> REQ on an aligned accept.
  - In REQ, dmem_req=1 and all dmem_* outputs are stable until dmem_gnt=1.
  - REQ + gnt, store -> IDLE; next cycle wb_valid=1, wb_we=0.
  - REQ + gnt, load -> WAIT.
  - WAIT + dmem_rvalid -> IDLE; next cycle wb_valid=1, wb_we=1, wb_rd=rd, wb_data=extended load data.
  - dmem_req=0 outside REQ.
- dmem_rvalid is ignored in IDLE and REQ. A stale response after reset is dropped.
- Byte enables and store data:
  - SB: be=4'b0001<<addr[1:0], wdata={4{wdata[7:0]}}
  - SH: be = addr[1] ? 4'b1100 : 4'b0011, wdata={2{wdata[15:0]}}
  - SW: be=4'b1111, wdata=wdata
  - Loads: be per width, same rule as stores; dmem_we=0.
- Load extraction:
  - Byte lane = rdata[8*addr[1:0] +: 8].
  - Halfword = rdata[16*addr[1] +: 16].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes through.
- Minimum latencies, with accept at cycle 0 and gnt in the first REQ cycle:
  - Store: REQ at cycle 1; wb_valid at cycle 2.
  - Load: REQ at cycle 1; rvalid at cycle 2 at the earliest; wb_valid at cycle 3.
  - Next accept is possible in the cycle wb_valid is high.
- Pulses: wb_valid and lsu_misalign last exactly one cycle.
- Reset mid-operation: abandons REQ/WAIT immediately; no wb_valid is generated for the aborted op.

Decomposition:
- Shared package:
  - Add lsu_state_t enum (LSU_IDLE, LSU_REQ, LSU_WAIT).
  - Reuse MEM_* opcodes, DATA_WIDTH and ADDR_WIDTH.
  - Add helper constant REG_ADDR_WIDTH=5.
- Sub-module: lsu_align (purely combinational). Inputs: op, addr[1:0], wdata, rdata. Outputs: be, lane-replicated wdata, extended load data, misalign flag. The top level holds the FSM and registers.

Test Plan:
- SW addr=0x100, wdata=0xDEADBEEF, gnt immediate -> dmem_addr=0x100, be=1111, dmem_wdata=0xDEADBEEF, we=1; wb_valid/wb_we=0 at cycle 2.
- LB addr=0x203, rdata=0x80xxxxxx, gnt held low 3 cycles, rvalid 2 cycles after gnt -> dmem_req held stable 4 cycles, dmem_addr=0x200, be=1000; wb_data=0xFFFFFF80, wb_rd correct, ex_ready=0 throughout.
- LHU addr=0x302, rdata=0x8001_1234 -> wb_data=0x00008001. LH same -> 0xFFFF8001. LBU addr=0x300 -> 0x00000034.
- SB addr=0x401 wdata=0x000000AB -> be=0010, dmem_wdata=0xABABABAB. SH addr=0x402 wdata=0x1234 -> be=1100, dmem_wdata=0x12341234.
- LW addr=0x102 -> no dmem_req; lsu_misalign pulse with lsu_bad_addr=0x102. SH addr=0x101 -> same, bad_addr=0x101. ex_ready stays 1.
- Load granted, rst_n pulsed low in WAIT, then rvalid arrives -> all outputs 0; no wb_valid; next LW addr=0x10 completes normally.

Source files
------------

// File: rtl/lsu_dmem_if_pkg.sv
// Shared definitions for the load/store unit: widths, memory opcodes, FSM states.
package lsu_dmem_if_pkg;

  localparam int DATA_WIDTH     = 32;
  localparam int ADDR_WIDTH     = 32;
  localparam int REG_ADDR_WIDTH = 5;

  // Memory operation opcodes shared with the execute stage
  typedef enum logic [2:0] {
    MEM_LB  = 3'd0,
    MEM_LH  = 3'd1,
    MEM_LW  = 3'd2,
    MEM_LBU = 3'd3,
    MEM_LHU = 3'd4,
    MEM_SB  = 3'd5,
    MEM_SH  = 3'd6,
    MEM_SW  = 3'd7
  } mem_op_t;

  typedef enum logic [1:0] {
    LSU_IDLE = 2'd0,
    LSU_REQ  = 2'd1,
    LSU_WAIT = 2'd2
  } lsu_state_t;

  function automatic logic is_store(input mem_op_t op);
    return (op == MEM_SB) || (op == MEM_SH) || (op == MEM_SW);
  endfunction

endpackage

// File: rtl/lsu_dmem_if_align.sv
// Combinational lane logic: byte enables, store-data replication,
// load-data extraction/extension and alignment check.
module lsu_dmem_if_align
  import lsu_dmem_if_pkg::*;
(
  input  mem_op_t               op_i,
  input  logic [1:0]            addr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [DATA_WIDTH-1:0] rdata_i,
  output logic [3:0]            be_o,
  output logic [DATA_WIDTH-1:0] wdata_o,
  output logic [DATA_WIDTH-1:0] ldata_o,
  output logic                  misalign_o
);

  logic       is_byte;
  logic       is_half;
  logic [7:0] byte_lane;
  logic [15:0] half_lane;

  // Access size decode
  always_comb begin
    is_byte = (op_i == MEM_LB) || (op_i == MEM_LBU) || (op_i == MEM_SB);
    is_half = (op_i == MEM_LH) || (op_i == MEM_LHU) || (op_i == MEM_SH);
  end

  // Byte enables, replicated store data and alignment flag
  always_comb begin
    be_o       = 4'b1111;
    wdata_o    = wdata_i;
    misalign_o = (addr_i != 2'b00);
    if (is_byte) begin
      be_o       = 4'b0001 << addr_i;
      wdata_o    = {4{wdata_i[7:0]}};
      misalign_o = 1'b0;
    end else if (is_half) begin
      be_o       = addr_i[1] ? 4'b1100 : 4'b0011;
      wdata_o    = {2{wdata_i[15:0]}};
      misalign_o = addr_i[0];
    end
  end

  // Select the addressed byte and halfword out of the read word
  always_comb begin
    case (addr_i)
      2'd0:    byte_lane = rdata_i[7:0];
      2'd1:    byte_lane = rdata_i[15:8];
      2'd2:    byte_lane = rdata_i[23:16];
      default: byte_lane = rdata_i[31:24];
    endcase
    half_lane = addr_i[1] ? rdata_i[31:16] : rdata_i[15:0];
  end

  // Sign/zero extension per load opcode; stores yield zero
  always_comb begin
    case (op_i)
      MEM_LB:  ldata_o = {{24{byte_lane[7]}}, byte_lane};
      MEM_LBU: ldata_o = {24'd0, byte_lane};
      MEM_LH:  ldata_o = {{16{half_lane[15]}}, half_lane};
      MEM_LHU: ldata_o = {16'd0, half_lane};
      MEM_LW:  ldata_o = rdata_i;
      default: ldata_o = '0;
    endcase
  end

endmodule

// File: rtl/lsu_dmem_if.sv
// Load/store unit: accepts one memory op at a time, issues a word-aligned
// request, waits for grant/response and returns extended load data.
module lsu_dmem_if
  import lsu_dmem_if_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      ex_valid,
  output logic                      ex_ready,
  input  logic [2:0]                ex_mem_op,
  input  logic [ADDR_WIDTH-1:0]     ex_addr,
  input  logic [DATA_WIDTH-1:0]     ex_wdata,
  input  logic [REG_ADDR_WIDTH-1:0] ex_rd,
  output logic                      dmem_req,
  output logic                      dmem_we,
  output logic [ADDR_WIDTH-1:0]     dmem_addr,
  output logic [3:0]                dmem_be,
  output logic [DATA_WIDTH-1:0]     dmem_wdata,
  input  logic                      dmem_gnt,
  input  logic                      dmem_rvalid,
  input  logic [DATA_WIDTH-1:0]     dmem_rdata,
  output logic                      wb_valid,
  output logic                      wb_we,
  output logic [REG_ADDR_WIDTH-1:0] wb_rd,
  output logic [DATA_WIDTH-1:0]     wb_data,
  output logic                      lsu_misalign,
  output logic [ADDR_WIDTH-1:0]     lsu_bad_addr
);

  lsu_state_t                state_q;
  mem_op_t                   op_q;
  logic [1:0]                addr_lo_q;
  logic [REG_ADDR_WIDTH-1:0] rd_q;

  logic                      dmem_req_q, dmem_we_q;
  logic [ADDR_WIDTH-1:0]     dmem_addr_q;
  logic [3:0]                dmem_be_q;
  logic [DATA_WIDTH-1:0]     dmem_wdata_q;
  logic                      wb_valid_q, wb_we_q;
  logic [REG_ADDR_WIDTH-1:0] wb_rd_q;
  logic [DATA_WIDTH-1:0]     wb_data_q;
  logic                      misalign_q;
  logic [ADDR_WIDTH-1:0]     bad_addr_q;

  mem_op_t                   al_op;
  logic [1:0]                al_addr;
  logic [3:0]                al_be;
  logic [DATA_WIDTH-1:0]     al_wdata;
  logic [DATA_WIDTH-1:0]     al_ldata;
  logic                      al_misalign;

  // The lane logic sees the incoming op while idle and the latched op afterwards,
  // so a single instance serves both request formation and load extraction.
  always_comb begin
    if (state_q == LSU_IDLE) begin
      al_op   = mem_op_t'(ex_mem_op);
      al_addr = ex_addr[1:0];
    end else begin
      al_op   = op_q;
      al_addr = addr_lo_q;
    end
  end

  lsu_dmem_if_align u_align (
    .op_i       (al_op),
    .addr_i     (al_addr),
    .wdata_i    (ex_wdata),
    .rdata_i    (dmem_rdata),
    .be_o       (al_be),
    .wdata_o    (al_wdata),
    .ldata_o    (al_ldata),
    .misalign_o (al_misalign)
  );

  // Control FSM with registered memory and writeback outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= LSU_IDLE;
      op_q         <= MEM_LB;
      addr_lo_q    <= '0;
      rd_q         <= '0;
      dmem_req_q   <= 1'b0;
      dmem_we_q    <= 1'b0;
      dmem_addr_q  <= '0;
      dmem_be_q    <= '0;
      dmem_wdata_q <= '0;
      wb_valid_q   <= 1'b0;
      wb_we_q      <= 1'b0;
      wb_rd_q      <= '0;
      wb_data_q    <= '0;
      misalign_q   <= 1'b0;
      bad_addr_q   <= '0;
    end else begin
      wb_valid_q <= 1'b0;
      misalign_q <= 1'b0;
      case (state_q)
        LSU_IDLE: begin
          if (ex_valid) begin
            if (al_misalign) begin
              // Dropped without touching the memory port
              misalign_q <= 1'b1;
              bad_addr_q <= ex_addr;
            end else begin
              op_q         <= mem_op_t'(ex_mem_op);
              addr_lo_q    <= ex_addr[1:0];
              rd_q         <= ex_rd;
              dmem_req_q   <= 1'b1;
              dmem_we_q    <= is_store(mem_op_t'(ex_mem_op));
              dmem_addr_q  <= {ex_addr[ADDR_WIDTH-1:2], 2'b00};
              dmem_be_q    <= al_be;
              dmem_wdata_q <= al_wdata;
              state_q      <= LSU_REQ;
            end
          end
        end
        LSU_REQ: begin
          if (dmem_gnt) begin
            dmem_req_q <= 1'b0;
            if (is_store(op_q)) begin
              wb_valid_q <= 1'b1;
              wb_we_q    <= 1'b0;
              wb_rd_q    <= rd_q;
              wb_data_q  <= '0;
              state_q    <= LSU_IDLE;
            end else begin
              state_q    <= LSU_WAIT;
            end
          end
        end
        LSU_WAIT: begin
          if (dmem_rvalid) begin
            wb_valid_q <= 1'b1;
            wb_we_q    <= 1'b1;
            wb_rd_q    <= rd_q;
            wb_data_q  <= al_ldata;
            state_q    <= LSU_IDLE;
          end
        end
        default: state_q <= LSU_IDLE;
      endcase
    end
  end

  assign ex_ready     = (state_q == LSU_IDLE);
  assign dmem_req     = dmem_req_q;
  assign dmem_we      = dmem_we_q;
  assign dmem_addr    = dmem_addr_q;
  assign dmem_be      = dmem_be_q;
  assign dmem_wdata   = dmem_wdata_q;
  assign wb_valid     = wb_valid_q;
  assign wb_we        = wb_we_q;
  assign wb_rd        = wb_rd_q;
  assign wb_data      = wb_data_q;
  assign lsu_misalign = misalign_q;
  assign lsu_bad_addr = bad_addr_q;

endmodule

// File: tb/tb_lsu_dmem_if.sv
// Directed self-checking bench for lsu_dmem_if.
module tb_lsu_dmem_if;
  import lsu_dmem_if_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        ex_valid;
  logic        ex_ready;
  logic [2:0]  ex_mem_op;
  logic [31:0] ex_addr;
  logic [31:0] ex_wdata;
  logic [4:0]  ex_rd;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic        dmem_gnt;
  logic        dmem_rvalid;
  logic [31:0] dmem_rdata;
  logic        wb_valid;
  logic        wb_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        lsu_misalign;
  logic [31:0] lsu_bad_addr;

  int n_checks = 0;
  int n_fail   = 0;

  lsu_dmem_if dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ex_valid     (ex_valid),
    .ex_ready     (ex_ready),
    .ex_mem_op    (ex_mem_op),
    .ex_addr      (ex_addr),
    .ex_wdata     (ex_wdata),
    .ex_rd        (ex_rd),
    .dmem_req     (dmem_req),
    .dmem_we      (dmem_we),
    .dmem_addr    (dmem_addr),
    .dmem_be      (dmem_be),
    .dmem_wdata   (dmem_wdata),
    .dmem_gnt     (dmem_gnt),
    .dmem_rvalid  (dmem_rvalid),
    .dmem_rdata   (dmem_rdata),
    .wb_valid     (wb_valid),
    .wb_we        (wb_we),
    .wb_rd        (wb_rd),
    .wb_data      (wb_data),
    .lsu_misalign (lsu_misalign),
    .lsu_bad_addr (lsu_bad_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Present an op for one rising edge; returns at the negedge of cycle 1
  task automatic issue(input mem_op_t op, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [4:0] rd);
    ex_valid  = 1'b1;
    ex_mem_op = op;
    ex_addr   = addr;
    ex_wdata  = wdata;
    ex_rd     = rd;
    @(negedge clk);
    ex_valid  = 1'b0;
  endtask

  task automatic do_store(input string tag, input mem_op_t op, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] exp_be,
                          input logic [31:0] exp_wdata);
    issue(op, addr, wdata, 5'd0);
    check_eq({tag, ".req"},   {31'd0, dmem_req}, 32'd1);
    check_eq({tag, ".we"},    {31'd0, dmem_we}, 32'd1);
    check_eq({tag, ".addr"},  dmem_addr, {addr[31:2], 2'b00});
    check_eq({tag, ".be"},    {28'd0, dmem_be}, {28'd0, exp_be});
    check_eq({tag, ".wdata"}, dmem_wdata, exp_wdata);
    check_eq({tag, ".rdy0"},  {31'd0, ex_ready}, 32'd0);
    dmem_gnt = 1'b1;
    @(negedge clk);
    dmem_gnt = 1'b0;
    check_eq({tag, ".wbv"},   {31'd0, wb_valid}, 32'd1);
    check_eq({tag, ".wbwe"},  {31'd0, wb_we}, 32'd0);
    check_eq({tag, ".req0"},  {31'd0, dmem_req}, 32'd0);
    check_eq({tag, ".rdy1"},  {31'd0, ex_ready}, 32'd1);
    @(negedge clk);
    check_eq({tag, ".wbpulse"}, {31'd0, wb_valid}, 32'd0);
    $display("store %s addr=0x%08h be=%b wdata=0x%08h", tag, addr, dmem_be, dmem_wdata);
  endtask

  task automatic do_load(input string tag, input mem_op_t op, input logic [31:0] addr,
                         input logic [31:0] rdata, input logic [4:0] rd,
                         input logic [3:0] exp_be, input logic [31:0] exp_data);
    issue(op, addr, 32'h0, rd);
    check_eq({tag, ".req"},  {31'd0, dmem_req}, 32'd1);
    check_eq({tag, ".we"},   {31'd0, dmem_we}, 32'd0);
    check_eq({tag, ".addr"}, dmem_addr, {addr[31:2], 2'b00});
    check_eq({tag, ".be"},   {28'd0, dmem_be}, {28'd0, exp_be});
    dmem_gnt = 1'b1;
    @(negedge clk);
    dmem_gnt    = 1'b0;
    check_eq({tag, ".rdyw"}, {31'd0, ex_ready}, 32'd0);
    dmem_rvalid = 1'b1;
    dmem_rdata  = rdata;
    @(negedge clk);
    dmem_rvalid = 1'b0;
    check_eq({tag, ".wbv"},  {31'd0, wb_valid}, 32'd1);
    check_eq({tag, ".wbwe"}, {31'd0, wb_we}, 32'd1);
    check_eq({tag, ".wbrd"}, {27'd0, wb_rd}, {27'd0, rd});
    check_eq({tag, ".data"}, wb_data, exp_data);
    @(negedge clk);
    check_eq({tag, ".wbpulse"}, {31'd0, wb_valid}, 32'd0);
    $display("load  %s addr=0x%08h rdata=0x%08h expected=0x%08h", tag, addr, rdata, exp_data);
  endtask

  task automatic do_misalign(input string tag, input mem_op_t op, input logic [31:0] addr);
    issue(op, addr, 32'h5555_5555, 5'd3);
    check_eq({tag, ".req"}, {31'd0, dmem_req}, 32'd0);
    check_eq({tag, ".mis"}, {31'd0, lsu_misalign}, 32'd1);
    check_eq({tag, ".bad"}, lsu_bad_addr, addr);
    check_eq({tag, ".rdy"}, {31'd0, ex_ready}, 32'd1);
    check_eq({tag, ".wbv"}, {31'd0, wb_valid}, 32'd0);
    @(negedge clk);
    check_eq({tag, ".mispulse"}, {31'd0, lsu_misalign}, 32'd0);
    check_eq({tag, ".req2"}, {31'd0, dmem_req}, 32'd0);
    $display("misalign %s addr=0x%08h", tag, addr);
  endtask

  initial begin
    rst_n       = 1'b0;
    ex_valid    = 1'b0;
    ex_mem_op   = 3'd0;
    ex_addr     = '0;
    ex_wdata    = '0;
    ex_rd       = '0;
    dmem_gnt    = 1'b0;
    dmem_rvalid = 1'b0;
    dmem_rdata  = '0;
    repeat (2) @(negedge clk);
    check_eq("rst.req",   {31'd0, dmem_req}, 32'd0);
    check_eq("rst.addr",  dmem_addr, 32'd0);
    check_eq("rst.be",    {28'd0, dmem_be}, 32'd0);
    check_eq("rst.wbv",   {31'd0, wb_valid}, 32'd0);
    check_eq("rst.wbd",   wb_data, 32'd0);
    check_eq("rst.mis",   {31'd0, lsu_misalign}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("rst.rdy",   {31'd0, ex_ready}, 32'd1);
    $display("reset released");

    // Word store, immediate grant
    do_store("sw", MEM_SW, 32'h100, 32'hDEAD_BEEF, 4'b1111, 32'hDEAD_BEEF);

    // Byte load with a stalled grant: request must hold stable 4 cycles
    issue(MEM_LB, 32'h203, 32'h0, 5'd7);
    for (int i = 0; i < 4; i++) begin
      check_eq("lb.req",  {31'd0, dmem_req}, 32'd1);
      check_eq("lb.addr", dmem_addr, 32'h200);
      check_eq("lb.be",   {28'd0, dmem_be}, 32'b1000);
      check_eq("lb.rdy",  {31'd0, ex_ready}, 32'd0);
      if (i == 3) dmem_gnt = 1'b1;
      else if (i == 1) begin
        // A response while still in REQ must be ignored
        dmem_rvalid = 1'b1;
        dmem_rdata  = 32'h1111_1111;
      end else dmem_rvalid = 1'b0;
      @(negedge clk);
    end
    dmem_gnt = 1'b0;
    check_eq("lb.req0", {31'd0, dmem_req}, 32'd0);
    check_eq("lb.rdyw", {31'd0, ex_ready}, 32'd0);
    @(negedge clk);
    check_eq("lb.nowb", {31'd0, wb_valid}, 32'd0);
    dmem_rvalid = 1'b1;
    dmem_rdata  = 32'h8012_3456;
    @(negedge clk);
    dmem_rvalid = 1'b0;
    check_eq("lb.wbv",  {31'd0, wb_valid}, 32'd1);
    check_eq("lb.wbwe", {31'd0, wb_we}, 32'd1);
    check_eq("lb.wbrd", {27'd0, wb_rd}, 32'd7);
    check_eq("lb.data", wb_data, 32'hFFFF_FF80);
    @(negedge clk);
    $display("load  lb addr=0x00000203 stalled grant data=0x%08h", wb_data);

    // Halfword/byte extraction and extension
    do_load("lhu", MEM_LHU, 32'h302, 32'h8001_1234, 5'd9,  4'b1100, 32'h0000_8001);
    do_load("lh",  MEM_LH,  32'h302, 32'h8001_1234, 5'd10, 4'b1100, 32'hFFFF_8001);
    do_load("lbu", MEM_LBU, 32'h300, 32'h8001_1234, 5'd11, 4'b0001, 32'h0000_0034);
    do_load("lhlo", MEM_LH, 32'h300, 32'h8001_9234, 5'd12, 4'b0011, 32'hFFFF_9234);

    // Sub-word stores: lane replication
    do_store("sb", MEM_SB, 32'h401, 32'h0000_00AB, 4'b0010, 32'hABAB_ABAB);
    do_store("sh", MEM_SH, 32'h402, 32'h0000_1234, 4'b1100, 32'h1234_1234);

    // Misaligned accesses are dropped
    do_misalign("lw_mis", MEM_LW, 32'h102);
    do_misalign("sh_mis", MEM_SH, 32'h101);

    // Reset while waiting for read data
    issue(MEM_LW, 32'h20, 32'h0, 5'd5);
    dmem_gnt = 1'b1;
    @(negedge clk);
    dmem_gnt = 1'b0;
    rst_n = 1'b0;
    #1;
    check_eq("arst.req",  {31'd0, dmem_req}, 32'd0);
    check_eq("arst.addr", dmem_addr, 32'd0);
    check_eq("arst.wbv",  {31'd0, wb_valid}, 32'd0);
    check_eq("arst.rdy",  {31'd0, ex_ready}, 32'd1);
    @(negedge clk);
    rst_n       = 1'b1;
    dmem_rvalid = 1'b1;
    dmem_rdata  = 32'hBAD0_BAD0;
    @(negedge clk);
    dmem_rvalid = 1'b0;
    check_eq("arst.stale", {31'd0, wb_valid}, 32'd0);
    @(negedge clk);
    check_eq("arst.stale2", {31'd0, wb_valid}, 32'd0);
    $display("reset mid-WAIT, stale response dropped");
    do_load("lw_after", MEM_LW, 32'h10, 32'hCAFE_F00D, 5'd4, 4'b1111, 32'hCAFE_F00D);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
